// File: rtl/fport_telemetry_scheduler_if.sv
// Bundle between the FPort uplink scheduler, the telemetry sources and the inverted UART.
// master is the scheduler's view; slave is the environment (sources, UART, pin driver).
interface fport_telemetry_scheduler_if #(
  parameter int num_sources = 4
);
  logic                      slot_start;
  logic [num_sources-1:0]    tel_valid;
  logic [16*num_sources-1:0] tel_app_id;
  logic [32*num_sources-1:0] tel_data;
  logic [num_sources-1:0]    tel_ack;
  logic                      uart_send;
  logic [7:0]                uart_byte;
  logic                      uart_done;
  logic                      tx_enable;
  logic                      busy;
  logic                      slot_dropped;

  modport master (
    input  slot_start, tel_valid, tel_app_id, tel_data, uart_done,
    output tel_ack, uart_send, uart_byte, tx_enable, busy, slot_dropped
  );

  modport slave (
    output slot_start, tel_valid, tel_app_id, tel_data, uart_done,
    input  tel_ack, uart_send, uart_byte, tx_enable, busy, slot_dropped
  );
endinterface

// File: rtl/fport_telemetry_scheduler.sv
// Round-robin FPort uplink scheduler: on each open slot it grants one telemetry source
// and streams a 10-byte checksummed frame into the UART while owning the line direction.
module fport_telemetry_scheduler #(
  parameter int num_sources = 4
) (
  input logic                          clock,
  input logic                          reset,
  fport_telemetry_scheduler_if.master  bus
);

  localparam int GW = $clog2(num_sources);

  typedef enum logic [2:0] {IDLE, GRANT, LOAD, SEND, WAIT_LOW, WAIT_HIGH, FINISH} state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    lastGrant_q, lastGrant_d;
  logic [15:0]      appId_q, appId_d;
  logic [31:0]      data_q, data_d;
  logic [7:0]       prim_q, prim_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       uartByte_q, uartByte_d;
  logic [3:0]       index_q, index_d;

  logic                   grantFound;
  logic [GW-1:0]          grantIdx;
  logic [15:0]            selAppId;
  logic [31:0]            selData;
  logic [7:0]             frameByte;
  logic [8:0]             sum9;
  logic [7:0]             crcNext;
  logic [num_sources-1:0] telAck;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGrant_q <= GW'(num_sources - 1);
      appId_q     <= '0;
      data_q      <= '0;
      prim_q      <= '0;
      crc_q       <= '0;
      uartByte_q  <= '0;
      index_q     <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      appId_q     <= appId_d;
      data_q      <= data_d;
      prim_q      <= prim_d;
      crc_q       <= crc_d;
      uartByte_q  <= uartByte_d;
      index_q     <= index_d;
    end
  end

  // Sources above the last grant win first; the second pass covers the wrap-around.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int i = 0; i < num_sources; i++) begin
      if (!grantFound && bus.tel_valid[i] && (GW'(i) > lastGrant_q)) begin
        grantFound = 1'b1;
        grantIdx   = GW'(i);
      end
    end
    for (int i = 0; i < num_sources; i++) begin
      if (!grantFound && bus.tel_valid[i] && (GW'(i) <= lastGrant_q)) begin
        grantFound = 1'b1;
        grantIdx   = GW'(i);
      end
    end
  end

  always_comb begin
    selAppId = '0;
    selData  = '0;
    for (int i = 0; i < num_sources; i++) begin
      if (grantIdx == GW'(i)) begin
        selAppId = bus.tel_app_id[16*i +: 16];
        selData  = bus.tel_data[32*i +: 32];
      end
    end
  end

  always_comb begin
    case (index_q)
      4'd0:    frameByte = 8'h08;
      4'd1:    frameByte = 8'h81;
      4'd2:    frameByte = prim_q;
      4'd3:    frameByte = appId_q[7:0];
      4'd4:    frameByte = appId_q[15:8];
      4'd5:    frameByte = data_q[7:0];
      4'd6:    frameByte = data_q[15:8];
      4'd7:    frameByte = data_q[23:16];
      4'd8:    frameByte = data_q[31:24];
      default: frameByte = 8'hFF - crc_q;
    endcase
  end

  // End-around carry folds bit 8 of the sum back into the low byte.
  assign sum9    = {1'b0, crc_q} + {1'b0, uartByte_q};
  assign crcNext = sum9[7:0] + {7'b0, sum9[8]};

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    appId_d     = appId_q;
    data_d      = data_q;
    prim_d      = prim_q;
    crc_d       = crc_q;
    uartByte_d  = uartByte_q;
    index_d     = index_q;
    case (state_q)
      IDLE: begin
        if (bus.slot_start) state_d = GRANT;
      end
      GRANT: begin
        crc_d   = '0;
        index_d = '0;
        if (grantFound) begin
          appId_d     = selAppId;
          data_d      = selData;
          prim_d      = 8'h10;
          lastGrant_d = grantIdx;
        end else begin
          appId_d = '0;
          data_d  = '0;
          prim_d  = 8'h00;
        end
        state_d = LOAD;
      end
      LOAD: begin
        uartByte_d = frameByte;
        state_d    = SEND;
      end
      SEND: begin
        if (index_q != 4'd9) crc_d = crcNext;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.uart_done) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (bus.uart_done) begin
          if (index_q != 4'd9) begin
            index_d = index_q + 4'd1;
            state_d = LOAD;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    telAck = '0;
    for (int i = 0; i < num_sources; i++) begin
      telAck[i] = (state_q == GRANT) && grantFound && (grantIdx == GW'(i));
    end
  end

  assign bus.tel_ack      = telAck;
  assign bus.uart_send    = (state_q == SEND);
  assign bus.uart_byte    = uartByte_q;
  assign bus.tx_enable    = (state_q == LOAD) || (state_q == SEND) ||
                            (state_q == WAIT_LOW) || (state_q == WAIT_HIGH);
  assign bus.busy         = (state_q != IDLE);
  assign bus.slot_dropped = bus.slot_start && (state_q != IDLE);

endmodule
